// File: rtl/mem_arbiter_pkg.sv
// Shared types for the tiny5 memory arbiter: access size, FSM state and requester id.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_master_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner selection; on a tie the requester not served last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  req,
  input  arb_master_t last,
  output logic        valid,
  output arb_master_t winner
);

  always_comb begin
    valid  = |req;
    winner = ARB_M0;
    case (req)
      2'b01:   winner = ARB_M0;
      2'b10:   winner = ARB_M1;
      2'b11:   winner = (last == ARB_M0) ? ARB_M1 : ARB_M0;
      default: winner = ARB_M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: fetch (m0) and load/store (m1) share one memory port,
// one registered transaction at a time, with an optional ack timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  mem_size_t         m0_size_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  mem_size_t         m1_size_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output mem_size_t         mem_size_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // A zero-width counter is illegal, so the disabled-timeout case keeps one bit.
  localparam int unsigned CNT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

  arb_state_t        state_q;
  arb_master_t       owner_q;
  arb_master_t       last_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pick_valid;
  arb_master_t       pick_winner;
  logic              grant;
  logic              timeout_hit;
  logic              done;
  logic              done_err;
  logic [DATA_W-1:0] done_rdata;

  rr_pick2 u_pick (
    .req    ({m1_req_i, m0_req_i}),
    .last   (last_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Grant is withheld while reset is asserted since nothing would be latched.
  assign grant       = reset_ni && (state_q == IDLE) && pick_valid;
  assign m0_gnt_o    = grant && (pick_winner == ARB_M0);
  assign m1_gnt_o    = grant && (pick_winner == ARB_M1);

  assign timeout_hit = (MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT - 1));
  assign done        = (state_q == BUSY) && (mem_ack_i || timeout_hit);
  assign done_err    = !mem_ack_i && timeout_hit;
  assign done_rdata  = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      owner_q     <= ARB_M0;
      last_q      <= ARB_M1;
      cnt_q       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_size_o  <= SIZE_BYTE;
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;
      m1_rdata_o  <= '0;
    end else begin
      m0_rvalid_o <= 1'b0;
      m0_err_o    <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rvalid_o <= 1'b0;
      m1_err_o    <= 1'b0;
      m1_rdata_o  <= '0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q   <= BUSY;
            owner_q   <= pick_winner;
            last_q    <= pick_winner;
            cnt_q     <= '0;
            mem_req_o <= 1'b1;
            if (pick_winner == ARB_M1) begin
              mem_we_o    <= m1_we_i;
              mem_addr_o  <= m1_addr_i;
              mem_wdata_o <= m1_wdata_i;
              mem_size_o  <= m1_size_i;
            end else begin
              mem_we_o    <= m0_we_i;
              mem_addr_o  <= m0_addr_i;
              mem_wdata_o <= m0_wdata_i;
              mem_size_o  <= m0_size_i;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state_q   <= IDLE;
            mem_req_o <= 1'b0;
            if (owner_q == ARB_M1) begin
              m1_rvalid_o <= 1'b1;
              m1_err_o    <= done_err;
              m1_rdata_o  <= done_rdata;
            end else begin
              m0_rvalid_o <= 1'b1;
              m0_err_o    <= done_err;
              m0_rdata_o  <= done_rdata;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_ni;
  logic [1:0]    rq;
  logic [1:0]    we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  mem_size_t     sz   [2];
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  logic m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  mem_size_t m0_size_i, m1_size_i;
  assign m0_req_i = rq[0];   assign m1_req_i = rq[1];
  assign m0_we_i  = we[0];   assign m1_we_i  = we[1];
  assign m0_addr_i = addr[0]; assign m1_addr_i = addr[1];
  assign m0_wdata_i = wdat[0]; assign m1_wdata_i = wdat[1];
  assign m0_size_i = sz[0];  assign m1_size_i = sz[1];

  logic m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  mem_size_t mem_size_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_size_i(m0_size_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_size_i(m1_size_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one outstanding transaction, its BUSY age, and the expected outputs.
  bit            m_busy = 1'b0;
  int            m_owner = 0;
  int            m_last = 1;
  int            m_age = 0;
  logic          e_req = 1'b0, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;
  mem_size_t     e_size = SIZE_BYTE;
  logic [1:0]    e_rv = '0, e_err = '0;
  logic [DW-1:0] e_rd [2] = '{default: '0};
  bit            e_zero = 1'b1;
  int            g_who = -1;
  int            done_who = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_txn(input bit err);
    m_busy = 1'b0;
    e_req = 1'b0;
    e_rv[m_owner] = 1'b1;
    e_err[m_owner] = err;
    e_rd[m_owner] = (err || e_we) ? '0 : mem_rdata_i;
    done_who = m_owner;
  endtask

  // Check this cycle's outputs at the falling edge, then advance the model across the next rising edge.
  task automatic cycle();
    @(negedge clk_i);
    g_who = -1;
    if (reset_ni && !m_busy && (rq != 2'b00))
      g_who = (rq == 2'b11) ? 1 - m_last : (rq[0] ? 0 : 1);
    chk("gnt0", m0_gnt_o, g_who == 0);
    chk("gnt1", m1_gnt_o, g_who == 1);
    chk("rvalid0", m0_rvalid_o, e_rv[0]);
    chk("rvalid1", m1_rvalid_o, e_rv[1]);
    chk("err0", m0_err_o, e_err[0]);
    chk("err1", m1_err_o, e_err[1]);
    chk("rdata0", m0_rdata_o, e_rd[0]);
    chk("rdata1", m1_rdata_o, e_rd[1]);
    chk("mem_req", mem_req_o, e_req);
    if (e_req || e_zero) begin
      chk("mem_we", mem_we_o, e_we);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("mem_size", mem_size_o, e_size);
    end
    e_rv = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0; e_zero = 1'b0; done_who = -1;
    if (!reset_ni) begin
      m_busy = 1'b0; m_last = 1; m_age = 0;
      e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_size = SIZE_BYTE; e_zero = 1'b1;
    end else if (g_who >= 0) begin
      m_busy = 1'b1; m_owner = g_who; m_last = g_who; m_age = 0;
      e_req = 1'b1; e_we = we[g_who]; e_addr = addr[g_who]; e_wdata = wdat[g_who]; e_size = sz[g_who];
    end else if (m_busy) begin
      m_age++;
      if (mem_ack_i) finish_txn(1'b0);
      else if (MW != 0 && m_age == MW) finish_txn(1'b1);
    end
    @(posedge clk_i); #1;
  endtask

  bit [1:0] pend, outs;

  initial begin
    reset_ni = 1'b0; rq = '0; we = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 2; i++) begin addr[i] = '0; wdat[i] = '0; sz[i] = SIZE_WORD; end
    @(posedge clk_i); #1;
    cycle(); cycle();
    reset_ni = 1'b1;
    cycle();

    // Single read on m0, ack two cycles after mem_req rises.
    rq[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0001_0000; sz[0] = SIZE_WORD;
    #1 chk("rd_gnt", m0_gnt_o, 1'b1);
    cycle();
    rq[0] = 1'b0;
    chk("rd_memreq_t1", mem_req_o, 1'b1);
    chk("rd_addr", mem_addr_o, 32'h0001_0000);
    cycle(); cycle();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    cycle();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h5555_AAAA;
    chk("rd_rvalid", m0_rvalid_o, 1'b1);
    chk("rd_rdata", m0_rdata_o, 32'h0000_0013);
    chk("rd_m1_quiet", m1_rvalid_o, 1'b0);
    chk("rd_memreq_off", mem_req_o, 1'b0);
    cycle();

    // Stray ack while idle.
    mem_ack_i = 1'b1;
    cycle();
    mem_ack_i = 1'b0;
    chk("stray_rvalid", m0_rvalid_o | m1_rvalid_o, 1'b0);
    chk("stray_err", m0_err_o | m1_err_o, 1'b0);
    cycle();

    // m1 write beats a waiting m0 (m0 was served last); m0 follows in the next IDLE.
    rq = 2'b11; we = 2'b10; addr[0] = 32'h200; addr[1] = 32'h100; wdat[1] = 32'hDEAD_BEEF;
    sz[1] = SIZE_WORD;
    #1 chk("wr_gnt1", m1_gnt_o, 1'b1);
    chk("wr_gnt0_wait", m0_gnt_o, 1'b0);
    cycle();
    rq[1] = 1'b0;
    chk("wr_we", mem_we_o, 1'b1);
    chk("wr_addr", mem_addr_o, 32'h100);
    chk("wr_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    #1 chk("wr_busy_nognt", m0_gnt_o, 1'b0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    cycle();
    mem_ack_i = 1'b0;
    chk("wr_rvalid1", m1_rvalid_o, 1'b1);
    chk("wr_rdata1", m1_rdata_o, 32'h0);
    #1 chk("wr_m0_next", m0_gnt_o, 1'b1);
    cycle();
    rq[0] = 1'b0; mem_ack_i = 1'b1;
    cycle();
    mem_ack_i = 1'b0;
    cycle();

    // Timeout on m0 with m1 pending; m1 granted alongside the error completion.
    rq[0] = 1'b1; addr[0] = 32'h300; mem_rdata_i = 32'hFFFF_FFFF;
    cycle();
    rq = 2'b10; we[1] = 1'b0; addr[1] = 32'h400;
    for (int k = 0; k < int'(MW); k++) begin
      chk($sformatf("to_memreq_%0d", k), mem_req_o, 1'b1);
      #1 chk($sformatf("to_nognt_%0d", k), m1_gnt_o, 1'b0);
      cycle();
    end
    chk("to_memreq_off", mem_req_o, 1'b0);
    chk("to_rvalid", m0_rvalid_o, 1'b1);
    chk("to_err", m0_err_o, 1'b1);
    chk("to_rdata", m0_rdata_o, 32'h0);
    #1 chk("to_m1_gnt", m1_gnt_o, 1'b1);
    cycle();
    rq[1] = 1'b0; mem_ack_i = 1'b1;
    cycle();
    mem_ack_i = 1'b0;
    cycle();

    // Reset one cycle after an m1 grant, ack during reset; then tie/alternation from reset.
    rq[1] = 1'b1;
    cycle();
    reset_ni = 1'b0; mem_ack_i = 1'b1;
    cycle();
    chk("rst_rvalid1", m1_rvalid_o, 1'b0);
    chk("rst_memreq", mem_req_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    cycle();
    reset_ni = 1'b1; rq = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1 chk($sformatf("alt_gnt0_%0d", c), m0_gnt_o, (c % 4) == 0);
      chk($sformatf("alt_gnt1_%0d", c), m1_gnt_o, (c % 4) == 2);
      cycle();
    end
    rq = 2'b00; mem_ack_i = 1'b0;
    cycle(); cycle(); cycle(); cycle(); cycle(); cycle();

    // Random traffic: requesters hold until granted and wait for completion.
    pend = '0; outs = '0;
    for (int n = 0; n < 3000; n++) begin
      reset_ni = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && !outs[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; rq[i] = 1'b1; we[i] = 1'($urandom_range(0, 1));
          addr[i] = $urandom; wdat[i] = $urandom; sz[i] = mem_size_t'($urandom_range(0, 2));
        end
      end
      mem_ack_i = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
      cycle();
      if (g_who >= 0) begin pend[g_who] = 1'b0; rq[g_who] = 1'b0; outs[g_who] = 1'b1; end
      if (done_who >= 0) outs[done_who] = 1'b0;
      if (!reset_ni) begin pend = '0; outs = '0; rq = '0; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter between the tiny5 core and a single memory port. Requester 0 is instruction fetch and requester 1 is load/store. Each accepted request is registered and presented to memory as one transaction, then held until memory acknowledges or a wait timeout expires. Arbitration is round-robin, so a load/store loop cannot starve fetch (or the reverse). The block sits between the datapath's fetch/data paths and the memory model/bus.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 255, maximum BUSY cycles without ack before timeout; 0 disables the timeout

Ports (mN = m0, m1):
- clk_i  in  1  clock; all logic on rising edge
- reset_ni  in  1  synchronous, active-low reset
- mN_req_i  in  1  request; held with its payload until mN_gnt_o
- mN_we_i  in  1  1 = write, 0 = read
- mN_addr_i  in  ADDR_W  address
- mN_wdata_i  in  DATA_W  write data
- mN_size_i  in  mem_size_t  access size (byte/half/word)
- mN_gnt_o  out  1  request accepted this cycle
- mN_rvalid_o  out  1  one-cycle completion pulse
- mN_rdata_o  out  DATA_W  read data, valid with rvalid; 0 for writes and on error
- mN_err_o  out  1  timeout; pulses together with rvalid
- mem_req_o  out  1  transaction active
- mem_we_o, mem_addr_o, mem_wdata_o, mem_size_o  out  -  latched payload
- mem_ack_i  in  1  transaction done; mem_rdata_i valid this cycle
- mem_rdata_i  in  DATA_W  read data

## Operation
- FSM arb_state_t has two states: IDLE and BUSY.
- IDLE:
  - Winner selection: if exactly one req_i is high, that requester wins. If both are high, the requester not recorded in last_q wins.
  - For the winner: gnt_o = 1 (combinational, IDLE only), payload latched into registers, owner_q = winner, last_q = winner, wait counter = 0, next state BUSY.
- BUSY:
  - mem_req_o = 1 with the latched payload, stable for the whole state.
  - mem_ack_i = 1: rdata captured (forced to 0 for writes), owner's rvalid pulses next cycle, next state IDLE.
  - No ack and MAX_WAIT != 0 and counter == MAX_WAIT-1: owner's rvalid and err pulse next cycle with rdata 0, next state IDLE.
  - Otherwise the counter increments. The counter is $clog2(MAX_WAIT+1) bits wide and saturates, never wraps.
- No gnt is issued in BUSY. Requests stay pending and requesters keep req_i and payload stable.
- mem_ack_i in IDLE is ignored.
- Only the owner's rvalid/err/rdata are driven. The other requester's outputs are 0.
- Reset (reset_ni = 0 at an edge), including mid-transaction:
  - state IDLE, last_q = m1 (m0 wins the first tie), counter 0.
  - Every output is 0 next cycle; an outstanding transaction's completion is dropped.
  - Memory must tolerate an abandoned request.

## Timing
- gnt in cycle T, mem_req_o from T+1.
- Ack in cycle T+k (k >= 1) gives rvalid in T+k+1. The FSM is IDLE in T+k+1, so the next gnt can coincide with that rvalid.
- Peak throughput is one transaction per 2 cycles (zero-wait memory: ack at T+1).
- Timeout: with no ack, mem_req_o stays high for cycles T+1..T+MAX_WAIT, then rvalid+err at T+MAX_WAIT+1.
- gnt is combinational from req_i and state. All other outputs are registered.

## Structure
- Add to definitions package: arb_state_t (IDLE, BUSY) and arb_master_t (ARB_M0, ARB_M1). Reuse the existing mem_size_t.
- One sub-module, rr_pick2: combinational winner selection from req[1:0] and last_q, outputs valid and winner. The FSM, payload registers and wait counter stay in mem_arbiter.

## Test plan
- Single read: m0 read addr 0x00010000, memory acks 2 cycles after mem_req_o rises with 0x00000013 -> m0_gnt_o at T, mem_req_o T+1..T+3, m0_rvalid_o at T+4 with rdata 0x00000013, m1 outputs 0.
- Tie then alternation: both requesting continuously from reset, zero-wait memory -> grant order m0, m1, m0, m1, one gnt every 2 cycles.
- Write: m1 write addr 0x100, wdata 0xDEADBEEF, size word -> mem_we_o = 1 with matching addr/data; m1_rvalid_o with rdata 0; m0 waits until the following IDLE.
- Timeout: MAX_WAIT = 4, memory never acks -> mem_req_o high exactly 4 cycles, then m0_rvalid_o = m0_err_o = 1, rdata 0; a pending m1 is granted in that same cycle.
- Reset mid-BUSY: assert reset_ni = 0 one cycle after gnt, ack arrives during reset -> no rvalid, all outputs 0; after release, m0 wins a tie.
- Stray ack: mem_ack_i pulsed in IDLE -> no rvalid/err, state unchanged.
